// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module   : ifu_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : ROM, redirect and decode handshake signals of the fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        input  fetch_en,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output fetch_en,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Synchronous FIFO of fetch entries with single-cycle flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (count_q == C_FULL);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A write into a full queue is only legal when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Instruction fetch with prefetch queue, redirect flush and decode
//            handshake. Define IFU_PERF_CNT_EN for fetch/flush counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt,
`endif
    instr_fetch_unit_if.master  bus
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_wdata;
    fetch_entry_t w_head;

    assign w_pop   = ~w_empty & bus.instr_ready;
    assign w_push  = bus.fetch_en & (~w_full | w_pop) & ~bus.redirect_valid;
    assign w_wdata = '{pc: fetch_pc_q, instr: bus.rom_data};

    assign bus.rom_addr    = fetch_pc_q;
    assign bus.instr_valid = ~w_empty;
    assign bus.instr_data  = w_empty ? NOP_INSTR : w_head.instr;
    assign bus.instr_pc    = w_empty ? 32'h0     : w_head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~32'h3;
        end else if (w_push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (w_push)             perf_fetch_q <= perf_fetch_q + 32'd1;
            if (bus.redirect_valid) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed vector bench for instr_fetch_unit against a model ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    typedef struct packed {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        chk;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] erom;
    } vec_t;

    localparam int NV = 36;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t tbl [NV];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return 32'h0000_0013 + (idx << 20);
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic rst, input logic fe, input logic rdy,
                                input logic rv, input logic [31:0] rpc, input logic chk,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] erom);
        vec_t v;
        v = '{rst: rst, fe: fe, rdy: rdy, rv: rv, rpc: rpc,
              chk: chk, ev: ev, epc: epc, erom: erom};
        return v;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic fe, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        reset              = rst;
        bus.fetch_en       = fe;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Rows are cycles: inputs held for the cycle, expected outputs seen during it.
        tbl[0]  = mk(1, 1, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0);
        tbl[1]  = mk(1, 1, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0);
        tbl[2]  = mk(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0);
        tbl[3]  = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'h0,         32'h4);
        tbl[4]  = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'h4,         32'h8);
        tbl[5]  = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'h8,         32'hC);
        tbl[6]  = mk(1, 1, 1, 0, 32'h0,         1, 1, 32'hC,         32'h10);
        tbl[7]  = mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0);
        tbl[8]  = mk(0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4);
        tbl[9]  = mk(0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'h8);
        tbl[10] = mk(0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'hC);
        for (int i = 11; i <= 16; i++) begin
            tbl[i] = mk(0, 1, 0, 0, 32'h0,      1, 1, 32'h0,         32'h10);
        end
        tbl[17] = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'h0,         32'h10);
        tbl[18] = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'h4,         32'h14);
        tbl[19] = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'h8,         32'h18);
        tbl[20] = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'hC,         32'h1C);
        tbl[21] = mk(0, 1, 1, 1, 32'h43,        1, 1, 32'h10,        32'h20);
        tbl[22] = mk(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         32'h40);
        tbl[23] = mk(0, 1, 1, 1, 32'hFFFF_FFF8, 1, 1, 32'h40,        32'h44);
        tbl[24] = mk(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         32'hFFFF_FFF8);
        tbl[25] = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        tbl[26] = mk(0, 1, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0);
        tbl[27] = mk(0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4);
        tbl[28] = mk(0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'h8);
        tbl[29] = mk(1, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'hC);
        tbl[30] = mk(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0);
        tbl[31] = mk(0, 1, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4);
        tbl[32] = mk(0, 0, 1, 0, 32'h0,         1, 1, 32'h0,         32'h8);
        tbl[33] = mk(0, 0, 1, 0, 32'h0,         1, 1, 32'h4,         32'h8);
        tbl[34] = mk(0, 0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h8);
        tbl[35] = mk(0, 0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h8);

        drive(tbl[0].rst, tbl[0].fe, tbl[0].rdy, tbl[0].rv, tbl[0].rpc);
        @(negedge clk);
        #1;
        for (int i = 1; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            #1;
            if (tbl[i].chk) begin
                chk32($sformatf("row%0d instr_valid", i), {31'b0, bus.instr_valid},
                      {31'b0, tbl[i].ev});
                chk32($sformatf("row%0d instr_pc", i), bus.instr_pc,
                      tbl[i].ev ? tbl[i].epc : 32'h0);
                chk32($sformatf("row%0d instr_data", i), bus.instr_data,
                      tbl[i].ev ? rom_word(tbl[i].epc) : 32'h0000_0013);
                chk32($sformatf("row%0d rom_addr", i), bus.rom_addr, tbl[i].erom);
            end
            step();
        end

        // Redirect while fetching is disabled: target latched, nothing queued until enabled.
        drive(1, 0, 1, 0, 32'h0);
        step();
        drive(0, 0, 1, 1, 32'h101);
        #1;
        chk32("h1 rom_addr before redirect", bus.rom_addr, 32'h0);
        step();
        drive(0, 0, 1, 0, 32'h0);
        #1;
        chk32("h1 rom_addr after redirect", bus.rom_addr, 32'h100);
        chk32("h1 instr_valid idle", {31'b0, bus.instr_valid}, 32'h0);
        step();
        chk32("h1 rom_addr hold", bus.rom_addr, 32'h100);
        bus.fetch_en = 1'b1;
        begin
            int waited;
            waited = 0;
            while (!bus.instr_valid && waited < 4) begin
                step();
                waited++;
            end
            chk32("h1 fetch latency", waited, 1);
        end
        chk32("h1 instr_pc target", bus.instr_pc, 32'h100);
        chk32("h1 instr_data target", bus.instr_data, rom_word(32'h100));

        // Six fetches, one redirect, then drain with fetching stopped.
        drive(1, 0, 0, 0, 32'h0);
        step();
        drive(0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk32("h2 rom_addr after six", bus.rom_addr, 32'h18);
        chk32("h2 instr_pc after six", bus.instr_pc, 32'h14);
        drive(0, 1, 1, 1, 32'h200);
        step();
        drive(0, 0, 1, 0, 32'h0);
        step();
        step();
        chk32("h2 instr_valid drained", {31'b0, bus.instr_valid}, 32'h0);
        chk32("h2 rom_addr hold", bus.rom_addr, 32'h200);
`ifdef IFU_PERF_CNT_EN
        chk32("h2 perf_fetch_cnt", perf_fetch_cnt, 32'd6);
        chk32("h2 perf_flush_cnt", perf_flush_cnt, 32'd1);
        drive(1, 0, 0, 0, 32'h0);
        step();
        chk32("h2 perf_fetch_cnt reset", perf_fetch_cnt, 32'd0);
        chk32("h2 perf_flush_cnt reset", perf_flush_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
